uart_fifo_bridge: RTL

Buffered register front-end for the UART transmit and receive engines. It replaces the single-byte TX load and RX holding path with parametrised TX and RX FIFOs, and adds sticky overflow status and a maskable, level-generating interrupt source. It sits between the processor port bus (OUT_PORT/IN_PORT/READ/WRITE strobes) and the existing `transmit`/`receive` engines.

---
 rtl/uart_fifo_bridge.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge
//   Buffered register front-end between the processor port bus and the UART
//   transmit/receive engines. TX and RX FIFOs, sticky overflow flags and a
//   maskable interrupt request.
//
// Ports
//   clk, reset           system clock, async active-high reset
//   OUT_PORT, WRITE0/1   port-bus write data; WRITE0 pushes TX, WRITE1 loads IMASK
//   READ[2:0], IN_PORT   one-hot read selects (RX pop / status / RX count), read data
//   INT_ACK, INTERRUPT   interrupt clear, registered interrupt request
//   TX_DATA, TX_LOAD     byte and load pulse to the transmit engine
//   TX_RDY               transmit engine idle
//   RX_DATA, RX_ERR      receive engine character and {OVF, FERR, PERR}
//   RX_RDY, RX_READ      receive engine data valid, capture acknowledge pulse
//
// Build option
//   UART_FIFO_ERR_EN     store RX_ERR per RX entry and report head errors
//
// TX launch FSM
//   state | meaning
//   IDLE  | engine free; launch when a byte is available and TX_RDY=1
//   BUSY  | byte handed over; wait for the engine to drop TX_RDY
module uart_fifo_bridge #(
  parameter int DATA_W    = 8,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16,
  parameter int RX_THRESH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] OUT_PORT,
  input  logic              WRITE0,
  input  logic              WRITE1,
  input  logic [2:0]        READ,
  output logic [DATA_W-1:0] IN_PORT,
  input  logic              INT_ACK,
  output logic              INTERRUPT,
  output logic [DATA_W-1:0] TX_DATA,
  output logic              TX_LOAD,
  input  logic              TX_RDY,
  input  logic [DATA_W-1:0] RX_DATA,
  input  logic [2:0]        RX_ERR,
  input  logic              RX_RDY,
  output logic              RX_READ
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
`ifdef UART_FIFO_ERR_EN
  localparam int RX_W = DATA_W + 3;
`else
  localparam int RX_W = DATA_W;
`endif
  localparam logic [TX_AW:0] TX_CNT_MAX    = (TX_AW+1)'(TX_DEPTH);
  localparam logic [RX_AW:0] RX_CNT_MAX    = (RX_AW+1)'(RX_DEPTH);
  localparam logic [RX_AW:0] RX_THRESH_CNT = (RX_AW+1)'(RX_THRESH);

  typedef enum logic {IDLE, BUSY} tx_state_t;
  tx_state_t tx_state;

  // TX FIFO
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [TX_AW-1:0]  tx_wr_ptr, tx_rd_ptr;
  logic [TX_AW:0]    tx_count;
  logic              tx_full, tx_empty, launch, tx_bypass, tx_pop, tx_push, tx_ovf_set;

  assign tx_full  = (tx_count == TX_CNT_MAX);
  assign tx_empty = (tx_count == '0);
  // An idle engine with an empty FIFO takes the WRITE0 byte directly so the
  // load pulse follows the push by one cycle.
  assign launch     = (tx_state == IDLE) && TX_RDY && (!tx_empty || WRITE0);
  assign tx_bypass  = launch && tx_empty;
  assign tx_pop     = launch && !tx_empty;
  assign tx_push    = WRITE0 && !tx_bypass && (!tx_full || tx_pop);
  assign tx_ovf_set = WRITE0 && tx_full && !tx_pop;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= OUT_PORT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      tx_count <= tx_count + {{TX_AW{1'b0}}, tx_push} - {{TX_AW{1'b0}}, tx_pop};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= IDLE;
      TX_LOAD  <= 1'b0;
      TX_DATA  <= '0;
    end else begin
      TX_LOAD <= 1'b0;
      case (tx_state)
        IDLE: if (launch) begin
          TX_DATA  <= tx_empty ? OUT_PORT : tx_mem[tx_rd_ptr];
          TX_LOAD  <= 1'b1;
          tx_state <= BUSY;
        end
        BUSY: if (!TX_RDY) tx_state <= IDLE;
        default: tx_state <= IDLE;
      endcase
    end
  end

  // RX FIFO
  logic [RX_W-1:0]  rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_AW:0]   rx_count;
  logic             rx_rdy_q, rx_full, rx_empty, rx_pop, rx_push, rx_ovf_set;
  logic [RX_W-1:0]  rx_wdata, rx_head;
  logic [2:0]       head_err;

  assign rx_full    = (rx_count == RX_CNT_MAX);
  assign rx_empty   = (rx_count == '0);
  assign rx_pop     = READ[0] && !rx_empty;
  // RX_READ doubles as the capture strobe: the engine data is still held.
  assign rx_push    = RX_READ && (!rx_full || rx_pop);
  assign rx_ovf_set = RX_READ && rx_full && !rx_pop;
  assign rx_head    = rx_mem[rx_rd_ptr];

`ifdef UART_FIFO_ERR_EN
  assign rx_wdata = {RX_ERR, RX_DATA};
  assign head_err = rx_empty ? 3'b000 : rx_head[DATA_W+2:DATA_W];
`else
  wire unused_rx_err = ^RX_ERR;
  assign rx_wdata = RX_DATA;
  assign head_err = 3'b000;
`endif

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_rdy_q  <= 1'b0;
      RX_READ   <= 1'b0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      rx_rdy_q <= RX_RDY;
      RX_READ  <= RX_RDY && !rx_rdy_q;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      rx_count <= rx_count + {{RX_AW{1'b0}}, rx_push} - {{RX_AW{1'b0}}, rx_pop};
    end
  end

  // Status, interrupt mask, interrupt request
  logic       rx_ovf, tx_ovf, status_rd;
  logic [3:0] imask, src, active, active_q;
  logic [7:0] status;

  assign status_rd = READ[1] && !READ[0];
  assign status    = {rx_ovf, tx_ovf, head_err, tx_full, tx_empty, !rx_empty};
  assign src       = {!tx_full, rx_ovf | tx_ovf | (|head_err), tx_empty, rx_count >= RX_THRESH_CNT};
  assign active    = src & imask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ovf    <= 1'b0;
      tx_ovf    <= 1'b0;
      imask     <= '0;
      active_q  <= '0;
      INTERRUPT <= 1'b0;
    end else begin
      // a set event in the same cycle as the status read wins
      rx_ovf   <= rx_ovf_set || (rx_ovf && !status_rd);
      tx_ovf   <= tx_ovf_set || (tx_ovf && !status_rd);
      if (WRITE1) imask <= OUT_PORT[3:0];
      active_q <= active;
      if (|(active & ~active_q)) INTERRUPT <= 1'b1;
      else if (INT_ACK)          INTERRUPT <= 1'b0;
    end
  end

  always_comb begin
    IN_PORT = '0;
    if (READ[0])      IN_PORT = rx_empty ? '0 : rx_head[DATA_W-1:0];
    else if (READ[1]) IN_PORT = DATA_W'(status);
    else if (READ[2]) IN_PORT = DATA_W'(rx_count);
  end

endmodule
